// File: rtl/vga_ctrl.sv
// VGA timing generator and pixel output stage (640x480@60 class), one pixel per clk.
// Latency: the address is combinational from the counters; pins lag the counters by DATA_LAT+1 cycles.
// Backpressure: none. The block free-runs; the pixel source must answer within DATA_LAT cycles.
// Optional macro VGA_CTRL_PATTERN_EN adds pattern_sel and an 8-bar colour test pattern.
module vga_ctrl #(
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 48,
  parameter int H_ACTIVE = 640,
  parameter int H_FRONT  = 16,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 33,
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT  = 10,
  parameter int DATA_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] vga_data,
`ifdef VGA_CTRL_PATTERN_EN
  input  logic        pattern_sel,
`endif
  output logic [9:0]  h_addr,
  output logic [9:0]  v_addr,
  output logic        addr_valid,
  output logic        hsync,
  output logic        vsync,
  output logic        valid,
  output logic [7:0]  vga_r,
  output logic [7:0]  vga_g,
  output logic [7:0]  vga_b,
  output logic        frame_start,
  output logic [15:0] frame_cnt
);

  localparam int H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;

  localparam logic [9:0]  H_LAST    = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST    = 10'(V_TOTAL - 1);
  localparam logic [9:0]  H_SYN_END = 10'(H_SYNC);
  localparam logic [9:0]  V_SYN_END = 10'(V_SYNC);
  localparam logic [9:0]  H_ACT_BEG = 10'(H_SYNC + H_BACK);
  localparam logic [9:0]  V_ACT_BEG = 10'(V_SYNC + V_BACK);
  // One bit wider: with no front porch the end of active equals the total.
  localparam logic [10:0] H_ACT_END = 11'(H_SYNC + H_BACK + H_ACTIVE);
  localparam logic [10:0] V_ACT_END = 11'(V_SYNC + V_BACK + V_ACTIVE);

  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
    $error("vga_ctrl: H_TOTAL and V_TOTAL must not exceed 1024");
  end
  if (DATA_LAT < 1 || DATA_LAT > 4) begin : g_bad_lat
    $error("vga_ctrl: DATA_LAT must be in 1..4");
  end

  logic [9:0]          r_h_cnt;
  logic [9:0]          r_v_cnt;
  logic [DATA_LAT-1:0] r_hs_d;
  logic [DATA_LAT-1:0] r_vs_d;
  logic [DATA_LAT-1:0] r_av_d;
  logic                r_hsync;
  logic                r_vsync;
  logic                r_valid;
  logic [23:0]         r_rgb;
  logic                r_frame_start;
  logic [15:0]         r_frame_cnt;
  logic                r_first_frame;

  logic                w_h_act;
  logic                w_v_act;
  logic                w_hs_raw;
  logic                w_vs_raw;
  logic                w_at_origin;
  logic [DATA_LAT:0]   w_hs_line;
  logic [DATA_LAT:0]   w_vs_line;
  logic [DATA_LAT:0]   w_av_line;
  logic [23:0]         w_pix;

  assign w_h_act     = (r_h_cnt >= H_ACT_BEG) && ({1'b0, r_h_cnt} < H_ACT_END);
  assign w_v_act     = (r_v_cnt >= V_ACT_BEG) && ({1'b0, r_v_cnt} < V_ACT_END);
  assign addr_valid  = w_h_act & w_v_act;
  assign h_addr      = w_h_act ? (r_h_cnt - H_ACT_BEG) : 10'd0;
  assign v_addr      = w_v_act ? (r_v_cnt - V_ACT_BEG) : 10'd0;
  assign w_hs_raw    = ~(r_h_cnt < H_SYN_END);
  assign w_vs_raw    = ~(r_v_cnt < V_SYN_END);
  assign w_at_origin = (r_h_cnt == 10'd0) && (r_v_cnt == 10'd0);

  // Stage 0 of each delay line is the raw value; the register holds stages 1..DATA_LAT.
  assign w_hs_line = {r_hs_d, w_hs_raw};
  assign w_vs_line = {r_vs_d, w_vs_raw};
  assign w_av_line = {r_av_d, addr_valid};

`ifdef VGA_CTRL_PATTERN_EN
  localparam logic [9:0] BAR_W = 10'(H_ACTIVE / 8);

  logic [DATA_LAT-1:0][9:0] r_ha_d;
  logic [DATA_LAT:0][9:0]   w_ha_line;
  logic [2:0]               w_bar_idx;
  logic [23:0]              w_bar;

  assign w_ha_line = {r_ha_d, h_addr};
  assign w_bar_idx = 3'(r_ha_d[DATA_LAT-1] / BAR_W);
  // Bars run white, yellow, cyan, green, magenta, red, blue, black: R off for idx[1], G for idx[2], B for idx[0].
  assign w_bar     = {{8{~w_bar_idx[1]}}, {8{~w_bar_idx[2]}}, {8{~w_bar_idx[0]}}};
  assign w_pix     = pattern_sel ? w_bar : vga_data;

  // Column delay line so the bar index lines up with the vga_data path.
  always_ff @(posedge clk) begin
    if (!rst) r_ha_d <= '0;
    else      r_ha_d <= w_ha_line[DATA_LAT-1:0];
  end
`else
  assign w_pix = vga_data;
`endif

  // Horizontal/vertical position counters; vertical steps on every line wrap.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_h_cnt <= 10'd0;
      r_v_cnt <= 10'd0;
    end else if (r_h_cnt == H_LAST) begin
      r_h_cnt <= 10'd0;
      r_v_cnt <= (r_v_cnt == V_LAST) ? 10'd0 : r_v_cnt + 10'd1;
    end else begin
      r_h_cnt <= r_h_cnt + 10'd1;
    end
  end

  // Delay syncs and blank by the source latency; reset flushes them to inactive.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_hs_d <= '1;
      r_vs_d <= '1;
      r_av_d <= '0;
    end else begin
      r_hs_d <= w_hs_line[DATA_LAT-1:0];
      r_vs_d <= w_vs_line[DATA_LAT-1:0];
      r_av_d <= w_av_line[DATA_LAT-1:0];
    end
  end

  // Pin register: samples delayed timing together with the returning pixel; colour forced to 0 in blanking.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_hsync <= 1'b1;
      r_vsync <= 1'b1;
      r_valid <= 1'b0;
      r_rgb   <= 24'd0;
    end else begin
      r_hsync <= r_hs_d[DATA_LAT-1];
      r_vsync <= r_vs_d[DATA_LAT-1];
      r_valid <= r_av_d[DATA_LAT-1];
      r_rgb   <= r_av_d[DATA_LAT-1] ? w_pix : 24'd0;
    end
  end

  // Frame pulse and counter; the frame that starts right after reset is not counted as completed.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_frame_start <= 1'b0;
      r_frame_cnt   <= 16'd0;
      r_first_frame <= 1'b1;
    end else begin
      r_frame_start <= w_at_origin;
      if (w_at_origin) begin
        if (r_first_frame) r_first_frame <= 1'b0;
        else               r_frame_cnt   <= r_frame_cnt + 16'd1;
      end
    end
  end

  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign valid       = r_valid;
  assign vga_r       = r_rgb[23:16];
  assign vga_g       = r_rgb[15:8];
  assign vga_b       = r_rgb[7:0];
  assign frame_start = r_frame_start;
  assign frame_cnt   = r_frame_cnt;

endmodule

// File: tb/tb_vga_ctrl.sv
// Bench for vga_ctrl with a shrunken timing so whole frames fit in a short run.
// A reference position model pushes expected pin values into a queue; they are popped DATA_LAT+1 cycles later.
// Hand sequences measure sync widths/periods, first/last pixel and a mid-frame reset.
module tb_vga_ctrl;

  localparam int HS = 3, HB = 2, HA = 8, HF = 2;
  localparam int VS = 2, VB = 1, VA = 3, VF = 1;
  localparam int LAT = 2;
  localparam int HT = HS + HB + HA + HF;
  localparam int VT = VS + VB + VA + VF;
  localparam int FRAME = HT * VT;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        vld;
    logic [23:0] rgb;
  } pins_t;

  typedef struct {
    logic [23:0] data;
    logic [7:0]  r;
    logic [7:0]  g;
    logic [7:0]  b;
  } vec_t;

  logic        clk;
  logic        rst;
  logic [23:0] vga_data;
  logic        pattern_sel;
  logic [9:0]  h_addr;
  logic [9:0]  v_addr;
  logic        addr_valid;
  logic        hsync;
  logic        vsync;
  logic        valid;
  logic [7:0]  vga_r;
  logic [7:0]  vga_g;
  logic [7:0]  vga_b;
  logic        frame_start;
  logic [15:0] frame_cnt;

  vga_ctrl #(
    .H_SYNC(HS), .H_BACK(HB), .H_ACTIVE(HA), .H_FRONT(HF),
    .V_SYNC(VS), .V_BACK(VB), .V_ACTIVE(VA), .V_FRONT(VF),
    .DATA_LAT(LAT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .vga_data(vga_data),
`ifdef VGA_CTRL_PATTERN_EN
    .pattern_sel(pattern_sel),
`endif
    .h_addr(h_addr),
    .v_addr(v_addr),
    .addr_valid(addr_valid),
    .hsync(hsync),
    .vsync(vsync),
    .valid(valid),
    .vga_r(vga_r),
    .vga_g(vga_g),
    .vga_b(vga_b),
    .frame_start(frame_start),
    .frame_cnt(frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pixel source: constant colour or {col,row} of the requested address, LAT cycles late.
  int          src_mode;
  logic [23:0] src_const;
  logic [23:0] src_pipe [LAT];
  always @(posedge clk) begin
    src_pipe[0] <= (src_mode == 1) ? {4'h0, h_addr, v_addr} : src_const;
    for (int i = 1; i < LAT; i++) src_pipe[i] <= src_pipe[i-1];
  end
  assign vga_data = src_pipe[LAT-1];

  int          n_chk, n_pass, cyc;
  int          exp_mode;
  logic [23:0] cur_exp;
  logic [23:0] bars [8];
  pins_t       exp_q [$];
  pins_t       inact;
  int          m_h, m_v;
  logic        m_first;
  logic [15:0] m_fc;

  logic hs_prev, vs_prev;
  int   cyc_rel, t_hf, t_vf, t_fs, hs_w, hs_per, vs_w, vs_per, fs_per, hs_first;
  logic [23:0] first_px, last_px;
  logic        seen_px;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [20:0] exp_addr(input int h, input int v);
    logic ha, va;
    ha = (h >= HS + HB) && (h < HS + HB + HA);
    va = (v >= VS + VB) && (v < VS + VB + VA);
    return {ha && va, ha ? 10'(h - HS - HB) : 10'd0, va ? 10'(v - VS - VB) : 10'd0};
  endfunction

  function automatic pins_t exp_pins(input int h, input int v);
    pins_t p;
    int col, row;
    logic [23:0] d;
    col   = h - HS - HB;
    row   = v - VS - VB;
    p.hs  = !(h < HS);
    p.vs  = !(v < VS);
    p.vld = (col >= 0) && (col < HA) && (row >= 0) && (row < VA);
    if (exp_mode == 1)      d = {4'h0, 10'(col), 10'(row)};
    else if (exp_mode == 2) d = bars[p.vld ? col / (HA / 8) : 0];
    else                    d = cur_exp;
    p.rgb = p.vld ? d : 24'd0;
    return p;
  endfunction

  task automatic step();
    pins_t e;
    logic  exp_fs;
    @(posedge clk);
    #1;
    cyc++;
    e = exp_q.pop_front();
    check("pins", {hsync, vsync, valid, vga_r, vga_g, vga_b}, e);
    exp_fs = (m_h == 0) && (m_v == 0);
    if (exp_fs) begin
      if (m_first) m_first = 1'b0;
      else         m_fc    = m_fc + 16'd1;
    end
    check("frame", {frame_start, frame_cnt}, {exp_fs, m_fc});
    if (m_h == HT - 1) begin
      m_h = 0;
      m_v = (m_v == VT - 1) ? 0 : m_v + 1;
    end else begin
      m_h++;
    end
    check("addr", {addr_valid, h_addr, v_addr}, exp_addr(m_h, m_v));
    exp_q.push_back(exp_pins(m_h, m_v));
    if (hs_prev && !hsync) begin
      if (t_hf >= 0) hs_per = cyc - t_hf;
      if (hs_first < 0) hs_first = cyc - cyc_rel;
      t_hf = cyc;
    end
    if (!hs_prev && hsync && t_hf >= 0) hs_w = cyc - t_hf;
    if (vs_prev && !vsync) begin
      if (t_vf >= 0) vs_per = cyc - t_vf;
      t_vf = cyc;
    end
    if (!vs_prev && vsync && t_vf >= 0) vs_w = cyc - t_vf;
    if (frame_start) begin
      if (t_fs >= 0) fs_per = cyc - t_fs;
      t_fs = cyc;
    end
    if (valid) begin
      if (!seen_px) first_px = {vga_r, vga_g, vga_b};
      seen_px = 1'b1;
      last_px = {vga_r, vga_g, vga_b};
    end
    hs_prev = hsync;
    vs_prev = vsync;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    cyc++;
    check("rst_pins", {hsync, vsync, valid, vga_r, vga_g, vga_b}, inact);
    check("rst_frame", {frame_start, frame_cnt}, 17'd0);
    check("rst_addr", {addr_valid, h_addr, v_addr}, 21'd0);
    m_h = 0; m_v = 0; m_first = 1'b1; m_fc = 16'd0;
    exp_q.delete();
    repeat (LAT) exp_q.push_back(inact);
    exp_q.push_back(exp_pins(0, 0));
    hs_prev = 1'b1; vs_prev = 1'b1;
    t_hf = -1; t_vf = -1; t_fs = -1; hs_first = -1;
    hs_w = -1; hs_per = -1; vs_w = -1; vs_per = -1; fs_per = -1;
    cyc_rel = cyc; seen_px = 1'b0;
    rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks passed %0d of %0d", n_pass, n_chk);
    $fatal(1);
  end

  initial begin
    vec_t vt [4];
    int   budget;
    vt[0] = '{data: 24'h123456, r: 8'h12, g: 8'h34, b: 8'h56};
    vt[1] = '{data: 24'hFFFFFF, r: 8'hFF, g: 8'hFF, b: 8'hFF};
    vt[2] = '{data: 24'hA5C30F, r: 8'hA5, g: 8'hC3, b: 8'h0F};
    vt[3] = '{data: 24'h000001, r: 8'h00, g: 8'h00, b: 8'h01};
    bars[0] = 24'hFFFFFF; bars[1] = 24'hFFFF00; bars[2] = 24'h00FFFF; bars[3] = 24'h00FF00;
    bars[4] = 24'hFF00FF; bars[5] = 24'hFF0000; bars[6] = 24'h0000FF; bars[7] = 24'h000000;
    inact = '{hs: 1'b1, vs: 1'b1, vld: 1'b0, rgb: 24'd0};
    n_chk = 0; n_pass = 0; cyc = 0;
    pattern_sel = 1'b0;
    src_mode = 0; src_const = 24'd0; exp_mode = 0; cur_exp = 24'd0;
    rst = 1'b0;

    // Constant-colour frames, one table entry per frame; switches land in blanking.
    do_reset(5);
    for (int i = 0; i < 4; i++) begin
      src_const = vt[i].data;
      cur_exp   = {vt[i].r, vt[i].g, vt[i].b};
      repeat (FRAME) step();
    end
    check("hs_first", hs_first, LAT + 1);
    check("hs_width", hs_w, HS);
    check("hs_period", hs_per, HT);
    check("vs_width", vs_w, VS * HT);
    check("vs_period", vs_per, FRAME);
    check("fs_period", fs_per, FRAME);
    check("frames_done", frame_cnt, 3);

    // Address-echo source: pixels must carry their own column/row.
    src_mode = 1; exp_mode = 1;
    do_reset(2);
    repeat (2 * FRAME) step();
    check("first_px", first_px, 24'd0);
    check("last_px", last_px, {4'h0, 10'(HA - 1), 10'(VA - 1)});

    // Mid-frame reset while the pins are inside an hsync pulse.
    budget = FRAME;
    while (!(m_h == HS + 1 && m_v == VS + VB + 1) && budget > 0) begin
      step();
      budget--;
    end
    check("reach_point", budget > 0, 1'b1);
    check("hs_low_before_rst", hsync, 1'b0);
    do_reset(1);
    repeat (FRAME) step();
    check("hs_first_after_rst", hs_first, LAT + 1);
    check("hs_width_after_rst", hs_w, HS);

`ifdef VGA_CTRL_PATTERN_EN
    // Colour bars must ignore vga_data entirely.
    src_mode = 0; src_const = 24'h5A5A5A; exp_mode = 2; pattern_sel = 1'b1;
    repeat (FRAME) step();
    pattern_sel = 1'b0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
